// File: rtl/jx2_gpr_scoreboard_pkg.sv
// jx2_gpr_scoreboard_pkg: shared register IDs, latency codes and counter width for the GPR scoreboard.
// JX2_SCB_TRACK_SPR_EN adds DLR/DHR/SP tracking slots.
package jx2_gpr_scoreboard_pkg;
  localparam int CNT_W = 3;
  localparam logic [5:0] JX2_GR_DLR = 6'h20;
  localparam logic [5:0] JX2_GR_DHR = 6'h21;
  localparam logic [5:0] JX2_GR_SP = 6'h22;
  localparam logic [5:0] JX2_GR_IMM = 6'h3E;
  localparam logic [5:0] JX2_GR_ZZR = 6'h3F;
  localparam logic [2:0] SCB_LAT_FWD = 3'd0;
  localparam logic [2:0] SCB_LAT_LOAD = 3'd7;
  localparam logic [CNT_W-1:0] SCB_CNT_LOAD = '1;
`ifdef JX2_SCB_TRACK_SPR_EN
  localparam int SCB_NSPR = 3;
`else
  localparam int SCB_NSPR = 0;
`endif
  // Latencies up to 1 forward from EX1, so they never occupy the register.
  function automatic logic [CNT_W-1:0] scbLatToCnt(input logic [2:0] lat);
    return (lat <= 3'd1) ? '0 : (lat == SCB_LAT_LOAD) ? SCB_CNT_LOAD : CNT_W'(lat - 3'd1);
  endfunction
endpackage

// File: rtl/jx2_gpr_scoreboard_cell.sv
// jx2_scb_cell: one register's in-flight countdown with accept > ldDone > countdown priority.
module jx2_scb_cell
  import jx2_gpr_scoreboard_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             hold,
  input  logic             accept,
  input  logic [CNT_W-1:0] acceptCnt,
  input  logic             ldDone,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);
  logic [CNT_W-1:0] cntNext;
  always_comb
    cntNext = accept ? acceptCnt
            : ldDone ? '0
            : (!hold && cnt != '0 && cnt != SCB_CNT_LOAD) ? cnt - CNT_W'(1)
            : cnt;
  always_ff @(posedge clock)
    if (reset) begin
      cnt <= '0;
      busy <= 1'b0;
    end else begin
      cnt <= cntNext;
      busy <= |cntNext;
    end
endmodule

// File: rtl/jx2_gpr_scoreboard.sv
// jx2_gpr_scoreboard: issue interlock for the 3-lane GPR file; stalls on busy sources and WAW on pending loads.
// JX2_SCB_TRACK_SPR_EN adds DLR/DHR/SP tracking (busyMask bits 32..34).
module jx2_gpr_scoreboard
  import jx2_gpr_scoreboard_pkg::*;
#(
  parameter int NUM_GPR = 32,
  parameter int LD_TIMEOUT = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        hold,
  input  logic [5:0]                  srcIdRs,
  input  logic [5:0]                  srcIdRt,
  input  logic [5:0]                  srcIdRu,
  input  logic [5:0]                  srcIdRv,
  input  logic [5:0]                  srcIdRx,
  input  logic [5:0]                  srcIdRy,
  input  logic                        issueValidA,
  input  logic                        issueValidB,
  input  logic                        issueValidC,
  input  logic [5:0]                  dstIdA,
  input  logic [5:0]                  dstIdB,
  input  logic [5:0]                  dstIdC,
  input  logic [2:0]                  dstLatA,
  input  logic [2:0]                  dstLatB,
  input  logic [2:0]                  dstLatC,
  input  logic                        ldDoneValid,
  input  logic [5:0]                  ldDoneId,
  output logic                        issueStall,
  output logic [NUM_GPR+SCB_NSPR-1:0] busyMask,
  output logic                        ldTimeout
);
  localparam int NTRK = NUM_GPR + SCB_NSPR;

  function automatic logic [5:0] slotId(input int i);
`ifdef JX2_SCB_TRACK_SPR_EN
    return (i == NUM_GPR) ? JX2_GR_DLR : (i == NUM_GPR + 1) ? JX2_GR_DHR
         : (i == NUM_GPR + 2) ? JX2_GR_SP : 6'(i);
`else
    return 6'(i);
`endif
  endfunction

  logic [CNT_W-1:0] cnt [NTRK];
  logic [NTRK-1:0] isLoad, srcBusy, dstLoad;
  logic acceptA, acceptB, acceptC, anyLoad;
  logic [CNT_W-1:0] latCntA, latCntB, latCntC;
  logic [7:0] toCnt;

  assign issueStall = |srcBusy || |dstLoad;
  assign acceptA = issueValidA && !issueStall && !hold;
  assign acceptB = issueValidB && !issueStall && !hold;
  assign acceptC = issueValidC && !issueStall && !hold;
  assign latCntA = scbLatToCnt(dstLatA);
  assign latCntB = scbLatToCnt(dstLatB);
  assign latCntC = scbLatToCnt(dstLatC);
  assign anyLoad = |isLoad;

  for (genvar g = 0; g < NTRK; g++) begin : gCell
    localparam logic [5:0] ID = slotId(g);
    logic hitA, hitB, hitC;
    assign hitA = acceptA && dstIdA == ID;
    assign hitB = acceptB && dstIdB == ID;
    assign hitC = acceptC && dstIdC == ID;
    jx2_scb_cell uCell (
      .clock     (clock),
      .reset     (reset),
      .hold      (hold),
      .accept    (hitA || hitB || hitC),
      .acceptCnt (hitC ? latCntC : hitB ? latCntB : latCntA),
      .ldDone    (ldDoneValid && ldDoneId == ID),
      .cnt       (cnt[g]),
      .busy      (busyMask[g])
    );
    assign isLoad[g] = cnt[g] == SCB_CNT_LOAD;
    assign srcBusy[g] = |cnt[g] && (srcIdRs == ID || srcIdRt == ID || srcIdRu == ID ||
                                    srcIdRv == ID || srcIdRx == ID || srcIdRy == ID);
    // A younger write must not land before the outstanding load overwrites it.
    assign dstLoad[g] = isLoad[g] && ((issueValidA && dstIdA == ID) ||
                                      (issueValidB && dstIdB == ID) ||
                                      (issueValidC && dstIdC == ID));
  end

  always_ff @(posedge clock)
    if (reset) begin
      toCnt <= '0;
      ldTimeout <= 1'b0;
    end else begin
      toCnt <= !anyLoad ? '0 : (!hold && toCnt != 8'(LD_TIMEOUT)) ? toCnt + 8'd1 : toCnt;
      ldTimeout <= ldTimeout || (anyLoad && !hold && toCnt == 8'(LD_TIMEOUT - 1));
    end
endmodule

// File: tb/tb_jx2_gpr_scoreboard.sv
// tb_jx2_gpr_scoreboard: directed and random stimulus against a cycle-count reference model.
module tb_jx2_gpr_scoreboard;
  import jx2_gpr_scoreboard_pkg::*;
  localparam int NB = 32 + SCB_NSPR;

  logic clock = 1'b0;
  logic reset, hold;
  logic [5:0] srcIdRs, srcIdRt, srcIdRu, srcIdRv, srcIdRx, srcIdRy;
  logic issueValidA, issueValidB, issueValidC;
  logic [5:0] dstIdA, dstIdB, dstIdC;
  logic [2:0] dstLatA, dstLatB, dstLatC;
  logic ldDoneValid;
  logic [5:0] ldDoneId;
  logic issueStall, ldTimeout;
  logic [NB-1:0] busyMask;

  int checks = 0, errors = 0;
  int remain [32];
  bit ldPend [32];
  int toCnt;
  bit toFlag;

  always #5 clock = ~clock;

  jx2_gpr_scoreboard dut (
    .clock(clock), .reset(reset), .hold(hold),
    .srcIdRs(srcIdRs), .srcIdRt(srcIdRt), .srcIdRu(srcIdRu),
    .srcIdRv(srcIdRv), .srcIdRx(srcIdRx), .srcIdRy(srcIdRy),
    .issueValidA(issueValidA), .issueValidB(issueValidB), .issueValidC(issueValidC),
    .dstIdA(dstIdA), .dstIdB(dstIdB), .dstIdC(dstIdC),
    .dstLatA(dstLatA), .dstLatB(dstLatB), .dstLatC(dstLatC),
    .ldDoneValid(ldDoneValid), .ldDoneId(ldDoneId),
    .issueStall(issueStall), .busyMask(busyMask), .ldTimeout(ldTimeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit mBusy(input logic [5:0] id);
    return id < 6'd32 && (ldPend[id[4:0]] || remain[id[4:0]] > 0);
  endfunction

  function automatic bit mWaw(input logic v, input logic [5:0] d);
    return v && d < 6'd32 && ldPend[d[4:0]];
  endfunction

  function automatic bit mStall();
    return mBusy(srcIdRs) || mBusy(srcIdRt) || mBusy(srcIdRu) || mBusy(srcIdRv) ||
           mBusy(srcIdRx) || mBusy(srcIdRy) || mWaw(issueValidA, dstIdA) ||
           mWaw(issueValidB, dstIdB) || mWaw(issueValidC, dstIdC);
  endfunction

  function automatic logic [NB-1:0] mMask();
    logic [NB-1:0] m = '0;
    for (int i = 0; i < 32; i++) m[i] = mBusy(6'(i));
    return m;
  endfunction

  function automatic void mClear();
    for (int i = 0; i < 32; i++) begin
      remain[i] = 0;
      ldPend[i] = 0;
    end
    toCnt = 0;
    toFlag = 0;
  endfunction

  function automatic void mIssue(input logic v, input logic [5:0] d, input logic [2:0] l);
    if (!v || d >= 6'd32) return;
    ldPend[d[4:0]] = (l == 3'd7);
    remain[d[4:0]] = (l == 3'd7 || l <= 3'd1) ? 0 : int'(l) - 1;
  endfunction

  task automatic cyc(input string tag);
    bit st, anyPend;
    #1;
    st = mStall();
    check({tag, ".stall"}, 64'(issueStall), 64'(st));
    check({tag, ".busy"}, 64'(busyMask), 64'(mMask()));
    check({tag, ".tmo"}, 64'(ldTimeout), 64'(toFlag));
    if (reset) mClear();
    else begin
      anyPend = 0;
      for (int i = 0; i < 32; i++) anyPend |= ldPend[i];
      if (!anyPend) toCnt = 0;
      else if (!hold) toCnt++;
      if (toCnt >= 255) toFlag = 1;
      if (!hold) for (int i = 0; i < 32; i++) if (remain[i] > 0) remain[i]--;
      if (ldDoneValid && ldDoneId < 6'd32) begin
        ldPend[ldDoneId[4:0]] = 0;
        remain[ldDoneId[4:0]] = 0;
      end
      if (!st && !hold) begin
        mIssue(issueValidA, dstIdA, dstLatA);
        mIssue(issueValidB, dstIdB, dstLatB);
        mIssue(issueValidC, dstIdC, dstLatC);
      end
    end
    @(negedge clock);
  endtask

  task automatic idle();
    reset = 0; hold = 0;
    {srcIdRs, srcIdRt, srcIdRu, srcIdRv, srcIdRx, srcIdRy} = {6{JX2_GR_ZZR}};
    {issueValidA, issueValidB, issueValidC} = 3'b000;
    {dstIdA, dstIdB, dstIdC} = {3{JX2_GR_ZZR}};
    {dstLatA, dstLatB, dstLatC} = 9'd0;
    ldDoneValid = 0; ldDoneId = 6'd0;
  endtask

  function automatic logic [5:0] rid();
    return ($urandom_range(0, 9) == 0) ? (6'h20 | 6'($urandom_range(0, 31))) : 6'($urandom_range(0, 15));
  endfunction

  initial begin
    int n;
    idle();
    reset = 1;
    repeat (2) @(negedge clock);
    mClear();
    reset = 0;
    srcIdRs = 6'd5;
    cyc("idle");
    check("rst.stall", 64'(issueStall), 64'd0);
    check("rst.busy", 64'(busyMask), 64'd0);
    check("rst.tmo", 64'(ldTimeout), 64'd0);

    idle(); issueValidA = 1; dstIdA = 6'd5; dstLatA = 3'd3;
    cyc("lat3.iss");
    idle(); srcIdRs = 6'd5;
    n = 0;
    repeat (4) begin
      n += int'(busyMask[5]);
      cyc("lat3.wait");
    end
    check("lat3.busyCycles", 64'(n), 64'd2);

    idle(); issueValidB = 1; dstIdB = 6'd9; dstLatB = 3'd7;
    cyc("ld9.iss");
    for (int i = 0; i < 10; i++) begin
      idle(); hold = 1; srcIdRs = 6'd9;
      ldDoneValid = (i == 3); ldDoneId = 6'd9;
      cyc("ld9.hold");
    end
    idle(); srcIdRs = 6'd9; issueValidA = 1; dstIdA = 6'd1; dstLatA = 3'd0;
    #1 check("ld9.release", 64'(issueStall), 64'd0);
    cyc("ld9.use");

    idle(); issueValidA = 1; dstIdA = 6'd12; dstLatA = 3'd5;
    issueValidC = 1; dstIdC = 6'd12; dstLatC = 3'd2;
    cyc("waw12.iss");
    idle();
    check("waw12.busy1", 64'(busyMask[12]), 64'd1);
    cyc("waw12.c1");
    check("waw12.busy0", 64'(busyMask[12]), 64'd0);

    idle(); issueValidA = 1; dstIdA = 6'd3; dstLatA = 3'd7;
    cyc("ld3.iss");
    idle(); issueValidA = 1; dstIdA = 6'd3; dstLatA = 3'd2; srcIdRs = 6'd0;
    repeat (5) begin
      #1 check("ld3.wawStall", 64'(issueStall), 64'd1);
      cyc("ld3.wait");
    end
    ldDoneValid = 1; ldDoneId = 6'd3;
    cyc("ld3.done");
    ldDoneValid = 0;
    #1 check("ld3.free", 64'(issueStall), 64'd0);
    cyc("ld3.reiss");

    repeat (600) begin
      srcIdRs = rid(); srcIdRt = rid(); srcIdRu = rid();
      srcIdRv = rid(); srcIdRx = rid(); srcIdRy = rid();
      issueValidA = 1'($urandom_range(0, 1)); dstIdA = rid(); dstLatA = 3'($urandom_range(0, 7));
      issueValidB = 1'($urandom_range(0, 1)); dstIdB = rid(); dstLatB = 3'($urandom_range(0, 7));
      issueValidC = 1'($urandom_range(0, 1)); dstIdC = rid(); dstLatC = 3'($urandom_range(0, 7));
      hold = ($urandom_range(0, 4) == 0);
      ldDoneValid = ($urandom_range(0, 2) == 0); ldDoneId = rid();
      reset = ($urandom_range(0, 199) == 0);
      cyc("rnd");
    end

    idle(); reset = 1;
    cyc("to.rst");
    idle(); issueValidA = 1; dstIdA = 6'd7; dstLatA = 3'd7;
    cyc("to.iss");
    idle();
    repeat (254) cyc("to.wait");
    check("to.before", 64'(ldTimeout), 64'd0);
    cyc("to.edge");
    check("to.rise", 64'(ldTimeout), 64'd1);
    hold = 1;
    repeat (3) cyc("to.sticky");
    check("to.stay", 64'(ldTimeout), 64'd1);
    idle(); reset = 1;
    cyc("to.midrst");
    idle();
    check("to.rstBusy", 64'(busyMask), 64'd0);
    check("to.rstTmo", 64'(ldTimeout), 64'd0);
    cyc("to.after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
